// File: rtl/ysyx_22040729_trap_csr_pkg.sv
// Shared constants for the machine-mode trap CSR unit: CSR addresses, status/enable
// bit positions, Zicsr op encodings and FSM state encoding.
package ysyx_22040729_trap_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

  localparam int unsigned MSTATUS_MIE   = 3;
  localparam int unsigned MSTATUS_MPIE  = 7;
  localparam int unsigned MSTATUS_MPP_L = 11;
  localparam int unsigned MSTATUS_MPP_H = 12;
  localparam int unsigned IRQ_MT        = 7;
  localparam int unsigned IRQ_ME        = 11;

  localparam logic [1:0] CSR_OP_RD = 2'b00;
  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

endpackage

// File: rtl/ysyx_22040729_mcycle.sv
// Free-running cycle counter with a write-load port; a load replaces the increment.
module ysyx_22040729_mcycle #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] count
);

  logic [DATA_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = wr_en ? wr_data : count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ysyx_22040729_trap_csr.sv
// Machine-mode trap CSR unit with registered trap/mret redirect.
// Optional mcycle counter enabled by defining YSYX_22040729_MCYCLE_EN.
module ysyx_22040729_trap_csr
  import ysyx_22040729_trap_csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] next_pc,
  input  logic                  exception,
  input  logic [DATA_WIDTH-1:0] excp_mcause,
  input  logic                  epc_select,
  input  logic                  mret,
  input  logic                  csr_en,
  input  logic [1:0]            csr_op,
  input  logic [11:0]           csr_addr,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic                  ext_irq_pend,
  input  logic                  tmr_irq_pend,
  output logic                  ext_irq,
  output logic                  tmr_irq,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  logic                  st_mie_q, st_mie_d;
  logic                  st_mpie_q, st_mpie_d;
  logic                  ie_mtie_q, ie_mtie_d;
  logic                  ie_meie_q, ie_meie_d;
  logic [DATA_WIDTH-1:0] mtvec_q, mtvec_d;
  logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
  logic [DATA_WIDTH-1:0] mcause_q, mcause_d;
  logic [DATA_WIDTH-1:0] mscratch_q, mscratch_d;
  logic [0:0]            state_q, state_d;
  logic                  redirect_q, redirect_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic                  active, take_trap, take_mret, do_csr;
  logic [DATA_WIDTH-1:0] wval;
  logic [DATA_WIDTH-1:0] mcycle_val;

  function automatic logic [DATA_WIDTH-1:0] csr_wval(
    input logic [1:0]            op,
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] wd
  );
    case (op)
      CSR_OP_RW: csr_wval = wd;
      CSR_OP_RS: csr_wval = old | wd;
      CSR_OP_RC: csr_wval = old & ~wd;
      default:   csr_wval = old;
    endcase
  endfunction

`ifdef YSYX_22040729_MCYCLE_EN
  logic mcycle_we;
  assign mcycle_we = do_csr && (csr_addr == CSR_MCYCLE);

  ysyx_22040729_mcycle #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (mcycle_we),
    .wr_data (wval),
    .count   (mcycle_val)
  );
`else
  assign mcycle_val = '0;
`endif

  // Priority: exception > mret > CSR write; REDIRECT ignores commit entirely.
  assign active    = commit && (state_q == ST_IDLE);
  assign take_trap = active && exception;
  assign take_mret = active && !exception && mret;
  assign do_csr    = active && !exception && !mret && csr_en && (csr_op != CSR_OP_RD);

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]   = st_mie_q;
        csr_rdata[MSTATUS_MPIE]  = st_mpie_q;
        csr_rdata[MSTATUS_MPP_L] = 1'b1;
        csr_rdata[MSTATUS_MPP_H] = 1'b1;
      end
      CSR_MIE: begin
        csr_rdata[IRQ_MT] = ie_mtie_q;
        csr_rdata[IRQ_ME] = ie_meie_q;
      end
      CSR_MIP: begin
        csr_rdata[IRQ_MT] = tmr_irq_pend;
        csr_rdata[IRQ_ME] = ext_irq_pend;
      end
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MCYCLE:   csr_rdata = mcycle_val;
      default:      csr_rdata = '0;
    endcase
  end

  assign wval = csr_wval(csr_op, csr_rdata, csr_wdata);

  always_comb begin
    st_mie_d      = st_mie_q;
    st_mpie_d     = st_mpie_q;
    ie_mtie_d     = ie_mtie_q;
    ie_meie_d     = ie_meie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mscratch_d    = mscratch_q;
    redirect_pc_d = redirect_pc_q;
    redirect_d    = 1'b0;
    state_d       = ST_IDLE;

    if (take_trap) begin
      st_mpie_d     = st_mie_q;
      st_mie_d      = 1'b0;
      mepc_d        = epc_select ? next_pc : pc;
      mepc_d[1:0]   = 2'b00;
      mcause_d      = excp_mcause;
      redirect_pc_d = mtvec_q;
      redirect_d    = 1'b1;
      state_d       = ST_REDIRECT;
    end else if (take_mret) begin
      st_mie_d      = st_mpie_q;
      st_mpie_d     = 1'b1;
      redirect_pc_d = mepc_q;
      redirect_d    = 1'b1;
      state_d       = ST_REDIRECT;
    end else if (do_csr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          st_mie_d  = wval[MSTATUS_MIE];
          st_mpie_d = wval[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          ie_mtie_d = wval[IRQ_MT];
          ie_meie_d = wval[IRQ_ME];
        end
        CSR_MTVEC:    mtvec_d    = {wval[DATA_WIDTH-1:2], 2'b00};
        CSR_MEPC:     mepc_d     = {wval[DATA_WIDTH-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MSCRATCH: mscratch_d = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie_q      <= 1'b0;
      st_mpie_q     <= 1'b0;
      ie_mtie_q     <= 1'b0;
      ie_meie_q     <= 1'b0;
      mtvec_q       <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mscratch_q    <= '0;
      state_q       <= ST_IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      st_mie_q      <= st_mie_d;
      st_mpie_q     <= st_mpie_d;
      ie_mtie_q     <= ie_mtie_d;
      ie_meie_q     <= ie_meie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mscratch_q    <= mscratch_d;
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign ext_irq     = ext_irq_pend && st_mie_q && ie_meie_q && (state_q == ST_IDLE);
  assign tmr_irq     = tmr_irq_pend && st_mie_q && ie_mtie_q && (state_q == ST_IDLE);
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ysyx_22040729_trap_csr.sv
// Directed bench for the trap CSR unit; expected values go through a scoreboard queue.
module tb_ysyx_22040729_trap_csr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit;
  logic [63:0] pc, next_pc, excp_mcause, csr_wdata;
  logic        exception, epc_select, mret, csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_rdata;
  logic        ext_irq_pend, tmr_irq_pend, ext_irq, tmr_irq, redirect;
  logic [63:0] redirect_pc;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  ysyx_22040729_trap_csr #(.DATA_WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit       (commit),
    .pc           (pc),
    .next_pc      (next_pc),
    .exception    (exception),
    .excp_mcause  (excp_mcause),
    .epc_select   (epc_select),
    .mret         (mret),
    .csr_en       (csr_en),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .ext_irq_pend (ext_irq_pend),
    .tmr_irq_pend (tmr_irq_pend),
    .ext_irq      (ext_irq),
    .tmr_irq      (tmr_irq),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_val(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    commit = 0; exception = 0; mret = 0; csr_en = 0; csr_op = 2'b00;
    epc_select = 0; pc = '0; next_pc = '0; excp_mcause = '0; csr_wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] v);
    csr_addr = addr;
    #1;
    expect_val(tag, v);
    check_val(csr_rdata);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic [63:0] d);
    commit = 1; csr_en = 1; csr_op = op; csr_addr = addr; csr_wdata = d;
    tick();
    clear_inputs();
  endtask

  // Commits a trap or mret and checks the redirect in the following cycle.
  task automatic redirect_op(input logic is_trap, input logic [63:0] cause, input logic sel,
                             input logic [63:0] p, input logic [63:0] np,
                             input logic [63:0] target, input string tag);
    commit = 1; exception = is_trap; mret = ~is_trap;
    excp_mcause = cause; epc_select = sel; pc = p; next_pc = np;
    expect_val({tag, "_redirect"}, 64'd1);
    expect_val({tag, "_redirect_pc"}, target);
    tick();
    clear_inputs();
    check_val({63'd0, redirect});
    check_val(redirect_pc);
  endtask

  initial begin
    clear_inputs();
    csr_addr = 12'h300; ext_irq_pend = 0; tmr_irq_pend = 0;
    rst_n = 0;
    @(negedge clk);
    rd("reset_mstatus", 12'h300, 64'h1800);
    expect_val("reset_redirect", 64'd0);    check_val({63'd0, redirect});
    expect_val("reset_redirect_pc", 64'd0); check_val(redirect_pc);
    rst_n = 1;
    tick();

    ext_irq_pend = 1; tmr_irq_pend = 1;
    rd("mip_both", 12'h344, 64'h880);
    expect_val("ext_irq_gated_mie0", 64'd0); check_val({63'd0, ext_irq});
    ext_irq_pend = 0; tmr_irq_pend = 0;
    rd("mip_none", 12'h344, 64'h0);
    rd("mie_reset", 12'h304, 64'h0);

    wr(12'h305, 2'b01, 64'h8000_0103);
    rd("mtvec_align", 12'h305, 64'h8000_0100);

    redirect_op(1'b1, 64'hb, 1'b0, 64'h8000_0010, 64'h8000_0014, 64'h8000_0100, "ecall");
    tick();
    expect_val("ecall_redirect_drop", 64'd0);  check_val({63'd0, redirect});
    expect_val("ecall_pc_hold", 64'h8000_0100); check_val(redirect_pc);
    rd("ecall_mepc", 12'h341, 64'h8000_0010);
    rd("ecall_mcause", 12'h342, 64'hb);
    rd("ecall_mstatus", 12'h300, 64'h1800);

    wr(12'h300, 2'b10, 64'h8);
    rd("mstatus_set_mie", 12'h300, 64'h1808);
    wr(12'h304, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    rd("mie_mask", 12'h304, 64'h880);
    wr(12'h304, 2'b11, 64'h800);
    rd("mie_rc", 12'h304, 64'h80);
    tmr_irq_pend = 1; ext_irq_pend = 1;
    #1;
    expect_val("tmr_irq_on", 64'd1);     check_val({63'd0, tmr_irq});
    expect_val("ext_irq_meie0", 64'd0);  check_val({63'd0, ext_irq});
    wr(12'h304, 2'b10, 64'h800);
    #1;
    expect_val("ext_irq_on", 64'd1);     check_val({63'd0, ext_irq});
    ext_irq_pend = 0;

    redirect_op(1'b1, 64'h8000_0000_0000_0007, 1'b1, 64'h8000_0020, 64'h8000_0024,
                64'h8000_0100, "timer");
    expect_val("tmr_irq_in_redirect", 64'd0); check_val({63'd0, tmr_irq});
    tick();
    rd("timer_mepc", 12'h341, 64'h8000_0024);
    rd("timer_mcause", 12'h342, 64'h8000_0000_0000_0007);
    rd("timer_mstatus", 12'h300, 64'h1880);
    expect_val("tmr_irq_after_trap", 64'd0); check_val({63'd0, tmr_irq});

    redirect_op(1'b0, 64'h0, 1'b0, 64'h8000_0100, 64'h8000_0104, 64'h8000_0024, "mret");
    tick();
    rd("mret_mstatus", 12'h300, 64'h1888);
    expect_val("tmr_irq_after_mret", 64'd1); check_val({63'd0, tmr_irq});
    tmr_irq_pend = 0;

    wr(12'h340, 2'b01, 64'h1234);
    rd("mscratch_rw", 12'h340, 64'h1234);
    csr_en = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 64'hdead;
    redirect_op(1'b1, 64'h2, 1'b0, 64'h8000_0040, 64'h8000_0044, 64'h8000_0100, "prio");
    commit = 1; exception = 1; mret = 1; csr_en = 1; csr_op = 2'b01;
    csr_addr = 12'h340; csr_wdata = 64'hbeef; excp_mcause = 64'h5; pc = 64'h8000_0080;
    tick();
    clear_inputs();
    expect_val("redirect_ignores_commit", 64'd0); check_val({63'd0, redirect});
    rd("prio_mscratch", 12'h340, 64'h1234);
    rd("prio_mcause", 12'h342, 64'h2);
    rd("prio_mepc", 12'h341, 64'h8000_0040);
    rd("prio_mstatus", 12'h300, 64'h1880);

    wr(12'h7C0, 2'b01, 64'h55);
    rd("unmapped", 12'h7C0, 64'h0);
    wr(12'h341, 2'b01, 64'h8000_0203);
    rd("mepc_align", 12'h341, 64'h8000_0200);

`ifdef YSYX_22040729_MCYCLE_EN
    wr(12'hB00, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    rd("mcycle_loaded", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rd("mcycle_wrap", 12'hB00, 64'h0);
    tick();
    rd("mcycle_inc", 12'hB00, 64'h1);
`else
    wr(12'hB00, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    rd("mcycle_absent", 12'hB00, 64'h0);
    tick();
    rd("mcycle_absent_later", 12'hB00, 64'h0);
`endif

    redirect_op(1'b1, 64'h3, 1'b0, 64'h8000_0300, 64'h8000_0304, 64'h8000_0100, "rst_mid");
    rst_n = 0;
    #1;
    expect_val("async_reset_redirect", 64'd0); check_val({63'd0, redirect});
    expect_val("async_reset_pc", 64'd0);       check_val(redirect_pc);
    rd("async_reset_mstatus", 12'h300, 64'h1800);
    rst_n = 1;
    tick();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
